lcd_bus_receiver: RTL and testbench
===================================

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops applied to RS, EN_IN and data_LCD (legal range 2-3).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; every flop is rising-edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port RS, input, 1 bit: register select; 0 = command, 1 = data.
REQ-005 SHALL have port EN_IN, input, 1 bit: LCD enable strobe, asynchronous to CLK.
REQ-006 SHALL have port data_LCD, input, 8 bits: LCD data bus (8-bit mode only).
REQ-007 SHALL have port rd_addr, input, 5 bits: character buffer read index, 0-15 = line 0, 16-31 = line 1.
REQ-008 SHALL have port clr_err, input, 1 bit: synchronous clear of err_ovf and err_addr.
REQ-009 SHALL have port rd_data, output, 8 bits: buffer[rd_addr], registered.
REQ-010 SHALL have port cursor, output, 5 bits: current write index.
REQ-011 SHALL have port disp_on, output, 1 bit: display-on flag.
REQ-012 SHALL have port busy, output, 1 bit: clear-fill in progress.
REQ-013 SHALL have port wr_pulse, output, 1 bit: one-cycle pulse per accepted data write.
REQ-014 SHALL have ports err_ovf and err_addr, outputs, 1 bit each: sticky error flags.

Function
REQ-015 SHALL pass RS, EN_IN and data_LCD through identical SYNC_STAGES flop chains so that all three stay aligned.
REQ-016 SHALL detect a transfer when the synchronized EN is 1 in the previous cycle and 0 in the current cycle, capturing the RS and data values from that previous cycle.
REQ-017 SHALL complete processing of each transfer on the cycle after detection; latency from the EN_IN falling edge to the effect is SYNC_STAGES+2 cycles.
REQ-018 SHALL, on a data transfer (RS=1) when not busy: write buffer[cursor]=data, pulse wr_pulse, then step cursor.
REQ-019 SHALL step cursor by +1 when inc=1 (31 wraps to 0) and by -1 when inc=0 (0 wraps to 31); 15<->16 is continuous.
REQ-020 SHALL decode commands (RS=0) by priority of the highest set bit:
- 0x01 clear: start the fill, set cursor=0, set inc=1.
- 0x02-0x03 home: set cursor=0.
- 0x04-0x07 entry mode: inc=bit1; bit0 ignored.
- 0x08-0x0F display control: disp_on=bit2.
- 0x10-0x1F shift: if bit3=0, step cursor in the direction of bit2 (1=right) per REQ-019; if bit3=1, no effect.
- 0x20-0x3F function set: no effect.
- 0x40-0x7F CGRAM address: enter discard mode.
- 0x80-0xFF DDRAM address with a=data[6:0]: a 0x00-0x0F gives cursor=a; a 0x40-0x4F gives cursor=16+a[3:0]; any other a leaves cursor unchanged and sets err_addr; in all cases discard mode exits.
- 0x00: no effect.
REQ-021 SHALL, in discard mode, drop data writes without changing the buffer, the cursor or wr_pulse.
REQ-022 SHALL implement the fill with the states IDLE and FILL. On entering FILL, an index starts at 0, one buffer entry is written with 0x20 per cycle, busy=1, and the block returns to IDLE after index 31, i.e. 32 cycles.
REQ-023 SHALL, for any transfer detected while busy=1: drop it and set err_ovf. A clear command received during FILL does not restart the fill.
REQ-024 SHALL update rd_data one cycle after rd_addr; a read and a write to the same index in the same cycle returns the old value.
REQ-025 SHALL let a set flag take priority over clr_err when both occur in the same cycle.

Reset
REQ-026 SHALL, while RST=0, force the following:
- rd_data=0, cursor=0, disp_on=0, busy=0, wr_pulse=0, err_ovf=0, err_addr=0.
- inc=1, discard mode off, state IDLE, all synchronizer flops 0.
REQ-027 SHALL leave buffer contents undefined after reset; software issues 0x01.
REQ-028 SHALL, if RST is asserted during FILL, abort the fill immediately and, after release, remain IDLE with busy=0.

Verification
REQ-029 Reset, then command 0x01, wait 33 cycles, read indices 0-31 -> every rd_data=0x20, cursor=0, busy high for exactly 32 cycles.
REQ-030 Commands 0x38, 0x0C, 0x06, then data 'H' (0x48), 'I' (0x49) -> buffer[0]=0x48, buffer[1]=0x49, cursor=2, disp_on=1, two wr_pulse pulses.
REQ-031 Command 0xCF then data 0x41, 0x42 -> buffer[31]=0x41, buffer[0]=0x42, cursor=1; then command 0x04 and data 0x43 -> buffer[1]=0x43, cursor=0.
REQ-032 Command 0x01 followed by data 0x55 sent 10 cycles later -> err_ovf=1 and buffer[0]=0x20; clr_err=1 -> err_ovf=0.
REQ-033 Commands 0x90 and 0x40, then data 0x77, then command 0x85 and data 0x78 -> err_addr=1, buffer unchanged by 0x77, buffer[5]=0x78.
REQ-034 Assert RST at fill index 10 -> all outputs at reset values per REQ-026; after release, busy=0 and the next command is accepted.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// HD44780-style 8-bit LCD bus snooper: synchronizes the asynchronous bus, decodes
// commands and data writes, and mirrors the 2x16 character buffer for readback.
module lcd_bus_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RS,
    input  logic       EN_IN,
    input  logic [7:0] data_LCD,
    input  logic [4:0] rd_addr,
    input  logic       clr_err,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       disp_on,
    output logic       busy,
    output logic       wr_pulse,
    output logic       err_ovf,
    output logic       err_addr
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    // Synchronizer chains, one per bus signal, all the same depth so they stay aligned.
    logic [SYNC_STAGES-1:0] rs_chain;
    logic [SYNC_STAGES-1:0] en_chain;
    logic [7:0]             data_chain [SYNC_STAGES];

    logic       rs_s;
    logic       en_s;
    logic [7:0] data_s;

    logic       en_d;
    logic       rs_d;
    logic [7:0] data_d;
    logic       detect;

    logic       xfer_valid;
    logic       xfer_rs;
    logic [7:0] xfer_data;

    state_t     state;
    state_t     state_next;
    logic [4:0] fill_idx;
    logic [4:0] fill_idx_next;
    logic [4:0] cursor_next;
    logic       inc;
    logic       inc_next;
    logic       disp_next;
    logic       discard;
    logic       discard_next;
    logic       pulse_next;
    logic       set_ovf;
    logic       set_addr;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_val;

    logic [7:0] mem [32];

    function automatic logic [4:0] step(input logic [4:0] c, input logic up);
        return up ? c + 5'd1 : c - 5'd1;
    endfunction

    assign rs_s   = rs_chain[SYNC_STAGES-1];
    assign en_s   = en_chain[SYNC_STAGES-1];
    assign data_s = data_chain[SYNC_STAGES-1];
    assign detect = en_d & ~en_s;
    assign busy   = (state == FILL);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rs_chain <= '0;
            en_chain <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) data_chain[i] <= '0;
        end else begin
            rs_chain      <= {rs_chain[SYNC_STAGES-2:0], RS};
            en_chain      <= {en_chain[SYNC_STAGES-2:0], EN_IN};
            data_chain[0] <= data_LCD;
            for (int i = 1; i < SYNC_STAGES; i++) data_chain[i] <= data_chain[i-1];
        end
    end

    // Falling edge of synchronized EN; RS/data are taken from the cycle EN was still high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_d       <= 1'b0;
            rs_d       <= 1'b0;
            data_d     <= '0;
            xfer_valid <= 1'b0;
            xfer_rs    <= 1'b0;
            xfer_data  <= '0;
        end else begin
            en_d       <= en_s;
            rs_d       <= rs_s;
            data_d     <= data_s;
            xfer_valid <= detect;
            xfer_rs    <= rs_d;
            xfer_data  <= data_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_next    = state;
        fill_idx_next = fill_idx;
        cursor_next   = cursor;
        inc_next      = inc;
        disp_next     = disp_on;
        discard_next  = discard;
        pulse_next    = 1'b0;
        set_ovf       = 1'b0;
        set_addr      = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = cursor;
        wr_val        = xfer_data;

        case (state)
            IDLE: begin
                if (xfer_valid && xfer_rs) begin
                    if (!discard) begin
                        wr_en       = 1'b1;
                        pulse_next  = 1'b1;
                        cursor_next = step(cursor, inc);
                    end
                end else if (xfer_valid) begin
                    casez (xfer_data)
                        8'b1???????: begin
                            discard_next = 1'b0;
                            if (xfer_data[6:4] == 3'b000)
                                cursor_next = {1'b0, xfer_data[3:0]};
                            else if (xfer_data[6:4] == 3'b100)
                                cursor_next = {1'b1, xfer_data[3:0]};
                            else
                                set_addr = 1'b1;
                        end
                        8'b01??????: discard_next = 1'b1;
                        8'b001?????: ;
                        8'b0001????: begin
                            if (!xfer_data[3]) cursor_next = step(cursor, xfer_data[2]);
                        end
                        8'b00001???: disp_next = xfer_data[2];
                        8'b000001??: inc_next = xfer_data[1];
                        8'b0000001?: cursor_next = 5'd0;
                        8'b00000001: begin
                            state_next    = FILL;
                            fill_idx_next = 5'd0;
                            cursor_next   = 5'd0;
                            inc_next      = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            FILL: begin
                wr_en         = 1'b1;
                wr_idx        = fill_idx;
                wr_val        = 8'h20;
                fill_idx_next = fill_idx + 5'd1;
                if (fill_idx == 5'd31) state_next = IDLE;
                // Anything arriving mid-fill, a repeated clear included, is dropped.
                if (xfer_valid) set_ovf = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            fill_idx <= '0;
            cursor   <= '0;
            inc      <= 1'b1;
            disp_on  <= 1'b0;
            discard  <= 1'b0;
            wr_pulse <= 1'b0;
            err_ovf  <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            state    <= state_next;
            fill_idx <= fill_idx_next;
            cursor   <= cursor_next;
            inc      <= inc_next;
            disp_on  <= disp_next;
            discard  <= discard_next;
            wr_pulse <= pulse_next;
            // A new error event wins over a simultaneous clear.
            if (set_ovf)      err_ovf <= 1'b1;
            else if (clr_err) err_ovf <= 1'b0;
            if (set_addr)     err_addr <= 1'b1;
            else if (clr_err) err_addr <= 1'b0;
        end
    end

    // NOTE: the character memory has no reset; software clears it with command 0x01.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_idx] <= wr_val;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rd_data <= '0;
        else      rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives LCD bus transfers and checks the
// buffer, cursor and flags against hand-computed values.
module tb_lcd_bus_receiver;

    logic       CLK;
    logic       RST;
    logic       RS;
    logic       EN_IN;
    logic [7:0] data_LCD;
    logic [4:0] rd_addr;
    logic       clr_err;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       disp_on;
    logic       busy;
    logic       wr_pulse;
    logic       err_ovf;
    logic       err_addr;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] rd;

    lcd_bus_receiver #(.SYNC_STAGES(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RS       (RS),
        .EN_IN    (EN_IN),
        .data_LCD (data_LCD),
        .rd_addr  (rd_addr),
        .clr_err  (clr_err),
        .rd_data  (rd_data),
        .cursor   (cursor),
        .disp_on  (disp_on),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .err_ovf  (err_ovf),
        .err_addr (err_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (wr_pulse) pulse_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus transfer; optionally pulses clr_err exactly on the processing edge.
    task automatic send(input logic rs_v, input logic [7:0] d, input bit pulse_clr = 0);
        @(negedge CLK);
        RS = rs_v;
        data_LCD = d;
        EN_IN = 1'b1;
        repeat (3) @(negedge CLK);
        EN_IN = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            if (pulse_clr && i == 3) clr_err = 1'b1;
            if (i == 4) clr_err = 1'b0;
        end
    endtask

    task automatic read_buf(input logic [4:0] a, output logic [7:0] d);
        @(negedge CLK);
        rd_addr = a;
        @(negedge CLK);
        d = rd_data;
    endtask

    initial begin
        RST = 1'b0;
        RS = 1'b0;
        EN_IN = 1'b0;
        data_LCD = '0;
        rd_addr = '0;
        clr_err = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_rd_data", rd_data, 0);
        check("rst_cursor", cursor, 0);
        check("rst_disp_on", disp_on, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_pulse", wr_pulse, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_err_addr", err_addr, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Clear fill
        busy_cnt = 0;
        send(1'b0, 8'h01);
        repeat (40) @(negedge CLK);
        check("fill_busy_cycles", busy_cnt, 32);
        check("fill_busy_done", busy, 0);
        check("fill_cursor", cursor, 0);
        for (int i = 0; i < 32; i++) begin
            read_buf(5'(i), rd);
            check($sformatf("fill_buf%0d", i), rd, 8'h20);
        end

        // Init sequence and two characters
        pulse_cnt = 0;
        send(1'b0, 8'h38);
        send(1'b0, 8'h0C);
        send(1'b0, 8'h06);
        send(1'b1, 8'h48);
        send(1'b1, 8'h49);
        check("hi_cursor", cursor, 2);
        check("hi_disp_on", disp_on, 1);
        check("hi_pulses", pulse_cnt, 2);
        read_buf(5'd0, rd);
        check("hi_buf0", rd, 8'h48);
        read_buf(5'd1, rd);
        check("hi_buf1", rd, 8'h49);

        // DDRAM 0x4F then wrap forward, then decrement mode wrap
        send(1'b0, 8'hCF);
        check("ddram_cf_cursor", cursor, 31);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        check("wrap_fwd_cursor", cursor, 1);
        send(1'b0, 8'h04);
        send(1'b1, 8'h43);
        check("dec_cursor", cursor, 0);
        read_buf(5'd31, rd);
        check("wrap_buf31", rd, 8'h41);
        read_buf(5'd0, rd);
        check("wrap_buf0", rd, 8'h42);
        read_buf(5'd1, rd);
        check("dec_buf1", rd, 8'h43);

        // Data write during fill -> overflow
        send(1'b0, 8'h01);
        send(1'b1, 8'h55);
        repeat (40) @(negedge CLK);
        check("ovf_set", err_ovf, 1);
        check("ovf_busy_done", busy, 0);
        check("ovf_cursor", cursor, 0);
        read_buf(5'd0, rd);
        check("ovf_buf0", rd, 8'h20);
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        @(negedge CLK);
        check("ovf_cleared", err_ovf, 0);

        // Bad DDRAM address (with clr_err on the same edge), CGRAM discard, good DDRAM
        pulse_cnt = 0;
        send(1'b0, 8'h90, 1);
        check("addr_err_beats_clr", err_addr, 1);
        check("addr_err_cursor", cursor, 0);
        send(1'b0, 8'h40);
        send(1'b1, 8'h77);
        check("discard_cursor", cursor, 0);
        check("discard_pulses", pulse_cnt, 0);
        send(1'b0, 8'h85);
        check("ddram_85_cursor", cursor, 5);
        send(1'b1, 8'h78);
        check("after_discard_cursor", cursor, 6);
        check("after_discard_pulses", pulse_cnt, 1);
        read_buf(5'd0, rd);
        check("discard_buf0", rd, 8'h20);
        read_buf(5'd5, rd);
        check("ddram_buf5", rd, 8'h78);
        check("addr_err_sticky", err_addr, 1);
        check("no_ovf", err_ovf, 0);

        // Cursor shift, home, wrap boundaries, 15->16 continuity
        send(1'b0, 8'h14);
        check("shift_right", cursor, 7);
        send(1'b0, 8'h18);
        check("shift_display_noop", cursor, 7);
        send(1'b0, 8'h10);
        check("shift_left", cursor, 6);
        send(1'b0, 8'h02);
        check("home", cursor, 0);
        send(1'b0, 8'h10);
        check("shift_left_wrap", cursor, 31);
        send(1'b0, 8'h14);
        check("shift_right_wrap", cursor, 0);
        send(1'b0, 8'h00);
        check("nop_cmd", cursor, 0);
        send(1'b0, 8'h8F);
        send(1'b1, 8'h61);
        check("line_cross_cursor", cursor, 16);
        read_buf(5'd15, rd);
        check("line_cross_buf15", rd, 8'h61);

        // Reset in the middle of a fill
        send(1'b0, 8'h01);
        repeat (8) @(negedge CLK);
        check("midfill_busy", busy, 1);
        RST = 1'b0;
        #1;
        check("midrst_rd_data", rd_data, 0);
        check("midrst_cursor", cursor, 0);
        check("midrst_disp_on", disp_on, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_pulse", wr_pulse, 0);
        check("midrst_err_ovf", err_ovf, 0);
        check("midrst_err_addr", err_addr, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        check("postrst_busy", busy, 0);
        send(1'b0, 8'h0C);
        check("postrst_disp_on", disp_on, 1);
        pulse_cnt = 0;
        send(1'b1, 8'h5A);
        check("postrst_cursor", cursor, 1);
        check("postrst_pulses", pulse_cnt, 1);
        read_buf(5'd0, rd);
        check("postrst_buf0", rd, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
